// File: rtl/round_shift_pipe.sv
// -----------------------------------------------------------------------------
// round_shift_pipe
//
// Two-stage pipelined rounding right-shifter.
//   Stage 1 registers floor((x + inc) / 2^s), where x is in_data extended by two
//   bits (sign- or zero-extended per SIGNED) and inc is picked by the rounding
//   mode (0 floor, 1 half-up, 2 half-even, 3 half-away-from-zero).
//   Stage 2 range-checks that result against OUT_WIDTH and registers it.
//
// Handshake: a beat moves across a port on a clock edge where valid && ready
// are both high. in_ready = !(out_valid && !out_ready), forced high during rst.
// When in_ready is 1 both stages advance together (bubbles included); when it
// is 0 every stage holds, so out_data/out_sat stay stable while stalled.
//
// Optional feature macro: ROUND_SHIFT_SAT_EN
//   defined   : out-of-range results clamp to the OUT_WIDTH max/min, out_sat=1,
//               and sat_count counts delivered saturated beats (sticks at FFFF).
//   undefined : out-of-range results wrap to their low OUT_WIDTH bits,
//               out_sat and sat_count are tied to 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   block accepts a beat this cycle
//   in_data    value to shift (IN_WIDTH bits)
//   in_shift   right-shift amount (SHIFT_WIDTH bits)
//   in_mode    rounding mode (2 bits)
//   out_valid  output beat present
//   out_ready  downstream accepts the beat
//   out_data   rounded, shifted, range-checked result (OUT_WIDTH bits)
//   out_sat    result was clamped (qualified by out_valid)
//   sat_count  number of saturated beats delivered (16 bits)
// -----------------------------------------------------------------------------
module round_shift_pipe #(
    parameter int IN_WIDTH    = 5,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 4,
    parameter int SIGNED      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [15:0]            sat_count
);

    // x is IN_WIDTH+2 bits; one extra bit on top keeps x + inc exact
    // (inc can be as large as 2^IN_WIDTH).
    localparam int AW        = IN_WIDTH + 3;
    localparam int MAX_SHIFT = IN_WIDTH + 1;
    // Compare width: room for the stage-1 result and for 2^OUT_WIDTH as a
    // positive signed constant.
    localparam int CW        = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 2;

    localparam logic signed [AW-1:0] ONE_A = AW'(1);

    // ------------------------------------------------------------------
    // Stage 1 combinational: rounding increment and shift
    // ------------------------------------------------------------------
    logic                 fill;
    logic [5:0]           s_eff;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] pow_s;
    logic signed [AW-1:0] half;
    logic signed [AW-1:0] mask;
    logic signed [AW-1:0] disc;
    logic signed [AW-1:0] inc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] res_d;
    logic                 kept_lsb;
    logic [1:0]           mode_eff;

    always_comb begin
        fill  = (SIGNED != 0) && in_data[IN_WIDTH-1];
        x_ext = {{3{fill}}, in_data};

        // Any shift beyond IN_WIDTH+1 already collapses x to 0 or -1, so
        // clamping the amount keeps the power-of-two inside AW bits.
        if (32'(in_shift) > 32'(MAX_SHIFT)) begin
            s_eff = 6'(MAX_SHIFT);
        end else begin
            s_eff = 6'(in_shift);
        end

        pow_s    = ONE_A << s_eff;
        half     = pow_s >>> 1;
        mask     = pow_s - ONE_A;
        disc     = x_ext & mask;
        // Bit s of x is the LSB of the kept (floor) quotient.
        kept_lsb = |(x_ext & pow_s);

        // Half-away-from-zero equals half-up when nothing can be negative.
        mode_eff = ((in_mode == 2'd3) && (SIGNED == 0)) ? 2'd1 : in_mode;

        inc = '0;
        if (s_eff != 6'd0) begin
            case (mode_eff)
                2'd1:    inc = half;
                2'd2:    inc = ((disc == half) && !kept_lsb) ? half - ONE_A : half;
                2'd3:    inc = x_ext[AW-1] ? half - ONE_A : half;
                default: inc = '0;
            endcase
        end

        sum   = x_ext + inc;
        res_d = sum >>> s_eff;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                   stage1_valid_q;
    logic signed [AW-1:0]   res_q;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic [OUT_WIDTH-1:0]   data_d;

    assign in_ready = rst || !(out_valid_q && !out_ready);

    // ------------------------------------------------------------------
    // Stage 2 combinational: range check
    // ------------------------------------------------------------------
    logic signed [CW-1:0] r_ext;
    logic                 unused_hi;

    assign r_ext     = {{(CW-AW){res_q[AW-1]}}, res_q};
    assign unused_hi = ^r_ext[CW-1:OUT_WIDTH];

`ifdef ROUND_SHIFT_SAT_EN
    localparam logic signed [CW-1:0] ONE_C = CW'(1);
    localparam logic signed [CW-1:0] HI = (SIGNED != 0) ? (ONE_C <<< (OUT_WIDTH-1)) - ONE_C
                                                        : (ONE_C <<< OUT_WIDTH) - ONE_C;
    localparam logic signed [CW-1:0] LO = (SIGNED != 0) ? -(ONE_C <<< (OUT_WIDTH-1))
                                                        : CW'(0);

    logic        sat_d;
    logic        out_sat_q;
    logic [15:0] sat_count_q;

    always_comb begin
        data_d = r_ext[OUT_WIDTH-1:0];
        sat_d  = 1'b0;
        if (r_ext > HI) begin
            data_d = HI[OUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end else if (r_ext < LO) begin
            data_d = LO[OUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat_q   <= 1'b0;
            sat_count_q <= 16'h0000;
        end else begin
            if (in_ready) begin
                out_sat_q <= sat_d;
            end
            // Count on delivery, not on stage-2 load; stick at all-ones.
            if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
                sat_count_q <= sat_count_q + 16'd1;
            end
        end
    end

    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;
`else
    // Out-of-range results simply keep their low OUT_WIDTH bits.
    assign data_d    = r_ext[OUT_WIDTH-1:0];
    assign out_sat   = 1'b0;
    assign sat_count = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_valid_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else if (in_ready) begin
            stage1_valid_q <= in_valid;
            res_q          <= res_d;
            out_valid_q    <= stage1_valid_q;
            out_data_q     <= data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_round_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_round_shift_pipe
//
// Four instances share one input stream and one out_ready:
//   a: unsigned IN5 OUT8 (defaults)   b: signed IN5 OUT8
//   c: unsigned IN5 OUT3              d: signed IN5 OUT3
// Because latency and handshake are identical, all four accept and deliver the
// same beats on the same edges, so one expected queue carries one entry per
// beat holding every instance's expected {sat, data} plus an acceptance stamp.
// -----------------------------------------------------------------------------
module tb_round_shift_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [4:0] in_data;
    logic [3:0] in_shift;
    logic [1:0] in_mode;

    logic        ir_a, ir_b, ir_c, ir_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic        os_a, os_b, os_c, os_d;
    logic [7:0]  od_a, od_b;
    logic [2:0]  od_c, od_d;
    logic [15:0] sc_a, sc_b, sc_c, sc_d;

    round_shift_pipe #(.IN_WIDTH(5), .OUT_WIDTH(8), .SHIFT_WIDTH(4), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .in_shift(in_shift), .in_mode(in_mode), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_sat(os_a), .sat_count(sc_a));

    round_shift_pipe #(.IN_WIDTH(5), .OUT_WIDTH(8), .SHIFT_WIDTH(4), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .in_shift(in_shift), .in_mode(in_mode), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_sat(os_b), .sat_count(sc_b));

    round_shift_pipe #(.IN_WIDTH(5), .OUT_WIDTH(3), .SHIFT_WIDTH(4), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
        .in_shift(in_shift), .in_mode(in_mode), .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_sat(os_c), .sat_count(sc_c));

    round_shift_pipe #(.IN_WIDTH(5), .OUT_WIDTH(3), .SHIFT_WIDTH(4), .SIGNED(1)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d), .in_data(in_data),
        .in_shift(in_shift), .in_mode(in_mode), .out_valid(ov_d), .out_ready(out_ready),
        .out_data(od_d), .out_sat(os_d), .sat_count(sc_d));

    // ---------------- bookkeeping ----------------
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  stall_total = 0;
    int  sat_cnt [4];
    bit  rand_bp  = 1'b0;

    // entry: [67:36] stamp, [35:27] a, [26:18] b, [17:9] c, [8:0] d ; each {sat, data[7:0]}
    logic [67:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fdiv(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic logic [8:0] model(input logic [4:0] din, input logic [3:0] sh,
                                         input logic [1:0] mode, input bit sgn, input int outw);
        int x, s, dv, half, inc, q, disc, r, lo, hi, msk, m;
        bit sat;
        logic [7:0] res;
        x = int'(din);
        if (sgn && din[4]) x = x - 32;
        s = (int'(sh) > 6) ? 6 : int'(sh);
        dv   = 1 << s;
        half = dv / 2;
        m    = int'(mode);
        if (m == 3 && !sgn) m = 1;
        q    = fdiv(x, dv);
        disc = x - q * dv;
        inc  = 0;
        if (s > 0) begin
            if (m == 1) inc = half;
            else if (m == 2) inc = (disc == half && (q % 2) == 0) ? half - 1 : half;
            else if (m == 3) inc = (x >= 0) ? half : half - 1;
        end
        r   = fdiv(x + inc, dv);
        lo  = sgn ? -(1 << (outw - 1)) : 0;
        hi  = sgn ? (1 << (outw - 1)) - 1 : (1 << outw) - 1;
        msk = (1 << outw) - 1;
        sat = 1'b0;
        res = 8'(r & msk);
`ifdef ROUND_SHIFT_SAT_EN
        if (r > hi) begin
            sat = 1'b1;
            res = 8'(hi & msk);
        end else if (r < lo) begin
            sat = 1'b1;
            res = 8'(lo & msk);
        end
`endif
        return {sat, res};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [67:0] e;
        logic [8:0]  ex [4];
        logic        ov [4];
        logic        ir [4];
        logic        os [4];
        logic [7:0]  od [4];
        logic [15:0] sc [4];
        ov[0] = ov_a; ov[1] = ov_b; ov[2] = ov_c; ov[3] = ov_d;
        ir[0] = ir_a; ir[1] = ir_b; ir[2] = ir_c; ir[3] = ir_d;
        os[0] = os_a; os[1] = os_b; os[2] = os_c; os[3] = os_d;
        od[0] = od_a; od[1] = od_b; od[2] = {5'b0, od_c}; od[3] = {5'b0, od_d};
        sc[0] = sc_a; sc[1] = sc_b; sc[2] = sc_c; sc[3] = sc_d;
        if (rst) begin
            // the coming reset edge discards everything in flight
            exp_q.delete();
            for (int i = 0; i < 4; i++) sat_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                check($sformatf("in_ready_%0d", i), 32'(ir[i]), 32'(!(ov[i] && !out_ready)));
            if (ov_a && !out_ready) stall_total++;
            if (ov_a || ov_b || ov_c || ov_d) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(ov_a | ov_b | ov_c | ov_d), 32'd0);
                end else begin
                    e = exp_q[0];
                    ex[0] = e[35:27]; ex[1] = e[26:18]; ex[2] = e[17:9]; ex[3] = e[8:0];
                    for (int i = 0; i < 4; i++) begin
                        check($sformatf("out_valid_%0d", i), 32'(ov[i]), 32'd1);
                        check($sformatf("out_data_%0d", i), 32'(od[i]), 32'(ex[i][7:0]));
                        check($sformatf("out_sat_%0d", i), 32'(os[i]), 32'(ex[i][8]));
                        check($sformatf("sat_count_%0d", i), 32'(sc[i]), 32'(sat_cnt[i]));
                    end
                    if (out_ready) begin
                        check("latency", 32'((cyc - stall_total) - int'(e[67:36])), 32'd2);
                        void'(exp_q.pop_front());
                        for (int i = 0; i < 4; i++)
                            if (ex[i][8] && sat_cnt[i] != 65535) sat_cnt[i]++;
                    end
                end
            end
            if (in_valid && ir_a) begin
                exp_q.push_back({32'(cyc - stall_total),
                                 model(in_data, in_shift, in_mode, 1'b0, 8),
                                 model(in_data, in_shift, in_mode, 1'b1, 8),
                                 model(in_data, in_shift, in_mode, 1'b0, 3),
                                 model(in_data, in_shift, in_mode, 1'b1, 3)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [4:0] d, input logic [3:0] sh, input logic [1:0] m);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_mode  = m;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            acc = ir_a;
            tick();
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int g = 0; g < 100; g++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int vecs [16][3] = '{
        '{22, 2, 0}, '{22, 2, 1}, '{22, 2, 2}, '{18, 2, 2},
        '{18, 2, 1}, '{12, 3, 1}, '{26, 2, 0}, '{26, 2, 1},
        '{26, 2, 2}, '{26, 2, 3}, '{16, 7, 0}, '{26, 0, 0},
        '{26, 0, 3}, '{31, 0, 0}, '{30, 0, 0}, '{16, 15, 3}};

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = '0;
        repeat (3) tick();

        // reset state
        @(negedge clk);
        check("rst_out_valid_a", 32'(ov_a), 32'd0);
        check("rst_out_valid_b", 32'(ov_b), 32'd0);
        check("rst_out_valid_c", 32'(ov_c), 32'd0);
        check("rst_out_valid_d", 32'(ov_d), 32'd0);
        check("rst_out_data_a", 32'(od_a), 32'd0);
        check("rst_out_data_d", 32'(od_d), 32'd0);
        check("rst_out_sat_c", 32'(os_c), 32'd0);
        check("rst_sat_count_c", 32'(sc_c), 32'd0);
        check("rst_in_ready", 32'(ir_a), 32'd1);
        tick();
        rst = 1'b0;

        // directed vectors, back to back, first beat right after reset release
        for (int i = 0; i < 16; i++)
            send_beat(5'(vecs[i][0]), 4'(vecs[i][1]), 2'(vecs[i][2]));
        drain();

        // backpressure: 4 beats, out_ready low for 3 cycles after first output
        send_beat(5'd22, 4'd2, 2'd1);
        send_beat(5'd31, 4'd0, 2'd0);
        send_beat(5'd26, 4'd2, 2'd2);
        in_valid  = 1'b1;
        in_data   = 5'd13;
        in_shift  = 4'd1;
        in_mode   = 2'd2;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(ir_a), 32'd0);
            check("bp_out_valid", 32'(ov_a), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        send_beat(5'd13, 4'd1, 2'd2);
        drain();

        // randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            send_beat(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)));
        end
        drain();

        // reset mid-stream with both stages full
        out_ready = 1'b0;
        send_beat(5'd31, 4'd0, 2'd0);
        send_beat(5'd30, 4'd0, 2'd1);
        in_valid = 1'b1;
        in_data  = 5'd7;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 32'(ir_a), 32'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_data   = 5'd22;
        in_shift  = 4'd2;
        in_mode   = 2'd1;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(ov_a), 32'd0);
        check("rst_mid_sat_count", 32'(sc_c), 32'd0);
        check("post_rst_accept", 32'(ir_a), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_out_valid_2cyc", 32'(ov_a), 32'd1);
        drain();

`ifdef ROUND_SHIFT_SAT_EN
        // long saturating run drives sat_count to its ceiling
        for (int i = 0; i < 65540; i++) send_beat(5'd31, 4'd0, 2'd0);
        drain();
        @(negedge clk);
        check("sat_count_max", 32'(sc_c), 32'hFFFF);
        tick();
        repeat (3) send_beat(5'd31, 4'd0, 2'd0);
        drain();
        @(negedge clk);
        check("sat_count_hold", 32'(sc_c), 32'hFFFF);
        tick();
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_shift_pipe.md
ROUND_SHIFT_PIPE -- requirements
Module: round_shift_pipe

Interface
REQ-001 Parameter IN_WIDTH, default 5, input data width in bits (2..32).
REQ-002 Parameter OUT_WIDTH, default 8, output data width in bits (2..32).
REQ-003 Parameter SHIFT_WIDTH, default 4, width of the shift-amount field.
REQ-004 Parameter SIGNED, default 0; 1 means in_data/out_data are two's complement, 0 means unsigned.
REQ-005 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  IN_WIDTH  value to shift.
REQ-010 in_shift  input  SHIFT_WIDTH  right-shift amount s.
REQ-011 in_mode  input  2  rounding mode: 0 truncate (floor), 1 half-up, 2 half-even, 3 half-away-from-zero.
REQ-012 out_valid  output  1  output beat present.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  OUT_WIDTH  rounded, shifted result.
REQ-015 out_sat  output  1  result was clamped (valid with out_valid).
REQ-016 sat_count  output  16  number of saturated beats delivered.

Function
REQ-017 Transfers occur on valid&&ready at either port; a beat is accepted when in_valid&&in_ready.
REQ-018 The block SHALL be a two-stage pipeline: stage 1 registers the rounded shift, stage 2 registers the range-checked output; latency is exactly 2 cycles with no stall.
REQ-019 in_ready SHALL equal !(out_valid && !out_ready); both stages advance together when in_ready=1 and hold all contents when in_ready=0.
REQ-020 Bubbles propagate: stage valid flags shift forward on advance; out_valid reflects stage-2 occupancy.
REQ-021 out_data/out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Arithmetic: x is in_data extended to IN_WIDTH+2 bits (sign- or zero-extended per SIGNED); result = floor((x + inc) / 2^s), computed exactly with no intermediate overflow.
REQ-023 inc: mode 0 -> 0; mode 1 -> 2^(s-1); mode 2 -> 2^(s-1), minus 1 when the discarded bits are exactly one half and the kept LSB is 0; mode 3 -> 2^(s-1) for x>=0, 2^(s-1)-1 for x<0.
REQ-024 s=0 SHALL pass x through unchanged in every mode.
REQ-025 s > IN_WIDTH+1 SHALL behave as s = IN_WIDTH+1.
REQ-026 Mode 3 with SIGNED=0 SHALL behave as mode 1.
REQ-027 Range check (stage 2): results outside the OUT_WIDTH range (signed or unsigned per SIGNED) are handled per REQ-033/034; results in range are output exactly and out_sat=0.
REQ-028 sat_count SHALL increment by 1 on each output transfer with out_sat=1 and saturate at 16'hFFFF (no wrap).

Reset
REQ-029 When rst=1 at a clock edge, stage valid flags, out_valid, out_data, out_sat and sat_count SHALL become 0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; no beat accepted before the reset edge is ever presented after it.
REQ-031 During rst=1, in_ready SHALL be 1 (the pipeline is empty), but beats presented in that cycle are discarded.
REQ-032 The first beat accepted in the cycle after rst deasserts SHALL appear at the output 2 cycles later.

Configuration
REQ-033 Macro ROUND_SHIFT_SAT_EN defined: out-of-range results clamp to the OUT_WIDTH max/min, out_sat=1, and sat_count counts per REQ-028.
REQ-034 ROUND_SHIFT_SAT_EN undefined: out-of-range results wrap (low OUT_WIDTH bits), out_sat and sat_count are tied to 0, and no saturation logic is present.

Verification
REQ-035 Default params (unsigned, IN 5, OUT 8), out_ready=1: in_data=22, s=2 -> out_data 5 (mode 0), 6 (mode 1), 6 (mode 2); in_data=18, s=2 -> 4 (mode 2), 5 (mode 1); in_data=12, s=3, mode 1 -> 2; each exactly 2 cycles after acceptance.
REQ-036 SIGNED=1, in_data=5'b11010 (-6), s=2 -> out_data -2 (mode 0), -1 (mode 1), -2 (mode 2), -2 (mode 3); in_data=5'b10000 (-16), s=7, mode 0 -> -1; s=0 passes -6 through.
REQ-037 OUT_WIDTH=3, SAT_EN defined: in_data=31, s=0 -> out_data 7, out_sat=1, sat_count 1; SAT_EN undefined -> out_data 7 from wrap, out_sat=0, sat_count 0; in_data=30, s=0 -> 6 (wrap) vs 7 with out_sat=1.
REQ-038 Backpressure: 4 back-to-back beats, out_ready low for 3 cycles after the first output -> in_ready low in those cycles, out_data held, all 4 results delivered in order with none lost or duplicated.
REQ-039 Reset mid-stream: rst pulsed for 1 cycle with both stages full -> out_valid=0 and sat_count=0 on the next cycle; a beat accepted the cycle after rst deasserts appears 2 cycles later.
REQ-040 sat_count pre-driven to 16'hFFFE by 3 saturating beats (forced or long run) -> reads FFFF and stays FFFF.
